sample_serializer: RTL
======================

# sample_serializer

Consumer end of the sample-request handshake. On each frame strobe it pulses `generate_next` to a sample source (e.g. the sine reader), waits for `sample_ready`, captures the 16-bit `sample`, and shifts it MSB-first to the audio DAC over a two-wire serial link (`sclk`/`sdata`). It sits between the note/sample generators and the DAC pins. It also detects a missing source response (timeout) and frame strobes that arrive while a frame is in progress (overrun).

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period; must be ≥1.
- `TIMEOUT`, default 7: max WAIT cycles before fallback; must be ≥1 and <256.

- `clk` in 1: system clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `frame_start` in 1: one-cycle strobe requesting a new sample frame.
- `clear_flags` in 1: synchronous clear of `timeout_err` and `overrun`.
- `generate_next` out 1: one-cycle request pulse to the sample source.
- `sample_ready` in 1: source strobe; `sample` is valid in the same cycle.
- `sample` in 16: two's-complement sample from the source.
- `sclk` out 1: serial bit clock; the DAC samples `sdata` on its rising edge.
- `sdata` out 1: serial data, MSB first.
- `frame_busy` out 1: high while state ≠ IDLE.
- `timeout_err` out 1: sticky; source failed to respond within TIMEOUT.
- `overrun` out 1: sticky; a `frame_start` arrived while not IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, SHIFT. All outputs are registered.
- **IDLE**
  - `frame_start`=1 → REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `generate_next`=1 for exactly this one cycle; then → WAIT.
  - Clear the wait counter.
- **WAIT**
  - `sample_ready`=1: load `sample` into the 16-bit shift register and into `last_sample`; → SHIFT.
  - Otherwise increment the wait counter.
  - If the counter reaches TIMEOUT with no ready: load `last_sample` into the shift register, set `timeout_err`; → SHIFT.
  - If ready and timeout coincide, ready wins and no error is flagged.
- **SHIFT**
  - Sends 16 bits; the bit counter runs 15 down to 0.
  - Each bit lasts 2·CLK_DIV cycles: `sclk`=0 for the first CLK_DIV cycles, then `sclk`=1 for CLK_DIV cycles.
  - `sdata` holds the bit for the whole bit period and changes only when `sclk` goes low.
  - After the last high phase of bit 0: → IDLE, `sclk`=0, `sdata`=0.
- `sample_ready` outside WAIT is ignored; no capture occurs.
- `frame_start` in any state other than IDLE:
  - The strobe is dropped and `overrun` is set.
  - This includes the final SHIFT cycle; a strobe is accepted only when the registered state is IDLE.
- `clear_flags` clears both sticky flags next cycle. A set event in the same cycle takes priority, so the flag stays 1.
- `last_sample` resets to 0.

## Timing
- Reset values: `generate_next`=0, `sclk`=0, `sdata`=0, `frame_busy`=0, `timeout_err`=0, `overrun`=0; state=IDLE. Shift register, counters and `last_sample` all reset to 0.
- Reset mid-frame aborts immediately. No partial bits are sent after deassertion.
- With `frame_start` high in cycle t:
  - `generate_next` and `frame_busy` are high in cycle t+1.
  - WAIT begins in cycle t+2.
- With a two-stage source (`sample_ready` two cycles after `generate_next`):
  - `sample_ready` is high in t+3 and capture happens at the end of t+3.
  - SHIFT starts in t+4, and the MSB appears on `sdata` in t+4.
- Frame length, measured from the first cycle of `frame_busy` to the last:
  - 1 (REQ) + W (WAIT cycles, 1..TIMEOUT) + 32·CLK_DIV.
  - CLK_DIV=4 with a two-stage source: 1+2+128 = 131 cycles.
- Back-to-back frames:
  - The next `frame_start` may be accepted in the first IDLE cycle.
  - The minimum `frame_start` period is therefore frame length + 1.

## Test plan
- **Normal frame:** CLK_DIV=4, two-stage source, `sample`=16'hA5C3, pulse `frame_start`.
  - `generate_next` is exactly one cycle, in t+1.
  - `sdata` bits sampled on rising `sclk` read 1010_0101_1100_0011.
  - 16 rising `sclk` edges; `frame_busy` lasts 131 cycles; both flags stay 0.
- **Timeout:** source never asserts `sample_ready`, `last_sample`=16'h7FFF from a prior frame.
  - After 7 WAIT cycles `timeout_err`=1 and 16'h7FFF is shifted out.
  - Repeat after a reset: 16'h0000 is shifted out.
- **Ready on the final WAIT cycle:** `sample_ready` arrives on the 7th WAIT cycle with 16'h8001.
  - 16'h8001 is shifted out and `timeout_err` stays 0.
- **Overrun:** `frame_start` pulses at mid-SHIFT and again in the final SHIFT cycle.
  - Both pulses are ignored and `overrun`=1; the frame completes unchanged.
  - `clear_flags` then returns `overrun` to 0.
  - `clear_flags` coincident with a new overrun leaves `overrun`=1.
- **Reset mid-SHIFT:** assert `reset` at bit 8.
  - All outputs go to 0 asynchronously and state is IDLE.
  - The next `frame_start` runs a complete, correct frame.
- **Stray ready:** `sample_ready` pulses in IDLE and in SHIFT with 16'hFFFF.
  - The shift register and `last_sample` are unaffected and serial output is unchanged.

Source files
------------

// File: rtl/sample_serializer.sv
// sample_serializer: requests a sample from a source on each frame strobe,
// captures it (or falls back to the previous sample on timeout) and shifts
// it MSB-first over a two-wire sclk/sdata link to the audio DAC.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   frame_start   in   one-cycle strobe requesting a new frame
//   clear_flags   in   synchronous clear of the sticky flags
//   generate_next out  one-cycle request pulse to the sample source
//   sample_ready  in   source strobe, sample valid in the same cycle
//   sample        in   16-bit two's-complement sample
//   sclk          out  serial bit clock (DAC samples on rising edge)
//   sdata         out  serial data, MSB first
//   frame_busy    out  high while a frame is in progress
//   timeout_err   out  sticky: source did not respond within TIMEOUT
//   overrun       out  sticky: frame_start seen while busy
module sample_serializer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned TIMEOUT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        clear_flags,
  output logic        generate_next,
  input  logic        sample_ready,
  input  logic [15:0] sample,
  output logic        sclk,
  output logic        sdata,
  output logic        frame_busy,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int unsigned SW     = 16;
  localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     shreg_q, shreg_d;
  logic [SW-1:0]     last_q, last_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              gen_q, gen_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              sdata_q, sdata_d;
  logic              to_q, to_d;
  logic              ov_q, ov_d;
  logic              to_set, ov_set;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      last_q  <= '0;
      wait_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gen_q   <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gen_q   <= gen_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    div_d   = div_q;
    to_set  = 1'b0;
    ov_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_REQ;
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready has priority over a coincident timeout
        if (sample_ready) begin
          shreg_d = sample;
          last_d  = sample;
          bit_d   = BIT_W'(SW - 1);
          div_d   = '0;
          state_d = S_SHIFT;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          shreg_d = last_q;
          to_set  = 1'b1;
          bit_d   = BIT_W'(SW - 1);
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          if (bit_q == '0) begin
            state_d = S_IDLE;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            shreg_d = {shreg_q[SW-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe is only accepted when the registered state is IDLE
    ov_set = frame_start && (state_q != S_IDLE);

    // Set events win over a coincident clear
    to_d = to_set | (to_q & ~clear_flags);
    ov_d = ov_set | (ov_q & ~clear_flags);

    // Outputs follow the next state so they line up with it cycle-for-cycle
    gen_d   = (state_d == S_REQ);
    busy_d  = (state_d != S_IDLE);
    sclk_d  = (state_d == S_SHIFT) && (div_d >= DIV_W'(CLK_DIV));
    sdata_d = (state_d == S_SHIFT) && shreg_d[SW-1];
  end

  assign generate_next = gen_q;
  assign frame_busy    = busy_q;
  assign sclk          = sclk_q;
  assign sdata         = sdata_q;
  assign timeout_err   = to_q;
  assign overrun       = ov_q;

endmodule
